// File: rtl/pr_dec_seq.sv
// Sequenced one-hot decoder: each accepted code drives a one-hot slot for HOLD cycles,
// with one pending code buffered. Define PR_DEC_SEQ_GAP_EN for a one-cycle gap between slots.
module pr_dec_seq #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned HOLD  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SEL_W-1:0]      in_code_i,
  input  logic                  in_en_i,
  output logic [2**SEL_W-1:0]   y_o,
  output logic                  y_valid_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(HOLD + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

`ifdef PR_DEC_SEQ_GAP_EN
  localparam state_e NextSlot = StGap;
`else
  localparam state_e NextSlot = StDrive;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] code_q, code_d;
  logic             en_q, en_d;
  logic             pend_valid_q, pend_valid_d;
  logic [SEL_W-1:0] pend_code_q, pend_code_d;
  logic             pend_en_q, pend_en_d;
  logic             xfer;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      code_q       <= '0;
      en_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      en_q         <= en_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_en_q    <= pend_en_d;
    end
  end

  assign xfer = in_valid_i && in_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    en_d         = en_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_en_d    = pend_en_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          code_d  = in_code_i;
          en_d    = in_en_i;
          cnt_d   = CntLoad;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_code_d  = in_code_i;
            pend_en_d    = in_en_i;
          end
        end else if (pend_valid_q) begin
          code_d       = pend_code_q;
          en_d         = pend_en_q;
          pend_valid_d = 1'b0;
          cnt_d        = CntLoad;
          state_d      = NextSlot;
        end else if (xfer) begin
          // Empty pending: the offered code bypasses straight into the drive register.
          code_d  = in_code_i;
          en_d    = in_en_i;
          cnt_d   = CntLoad;
          state_d = NextSlot;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        // Drive register and counter were loaded on entry; only buffer new input here.
        state_d = StDrive;
        if (xfer) begin
          pend_valid_d = 1'b1;
          pend_code_d  = in_code_i;
          pend_en_d    = in_en_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    y_o = '0;
    if (state_q == StDrive && en_q) begin
      y_o[code_q] = 1'b1;
    end
    in_ready_o = !pend_valid_q;
    y_valid_o  = (state_q == StDrive);
    done_o     = (state_q == StDrive) && (cnt_q == '0);
    busy_o     = (state_q != StIdle) || pend_valid_q;
  end

endmodule

// File: tb/tb_pr_dec_seq.sv
// Bench for pr_dec_seq: four instances (HOLD 4, 2, 1, 3) driven from a cycle-by-cycle vector
// table, plus a bounded hand-written slot-length check.
module tb_pr_dec_seq;

  localparam int NU = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s  [NU];
  logic       val_s  [NU];
  logic [1:0] code_s [NU];
  logic       en_s   [NU];
  logic [3:0] y_w    [NU];
  logic       rdy_w  [NU];
  logic       yv_w   [NU];
  logic       done_w [NU];
  logic       busy_w [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int unsigned H = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
    pr_dec_seq #(
      .SEL_W(2),
      .HOLD (H)
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst_s[g]),
      .in_valid_i(val_s[g]),
      .in_ready_o(rdy_w[g]),
      .in_code_i (code_s[g]),
      .in_en_i   (en_s[g]),
      .y_o       (y_w[g]),
      .y_valid_o (yv_w[g]),
      .done_o    (done_w[g]),
      .busy_o    (busy_w[g])
    );
  end

  typedef struct {
    int         u;
    logic       r;
    logic       v;
    logic [1:0] c;
    logic       e;
    logic [7:0] exp;  // {y, y_valid, done, busy, in_ready} after the edge
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int u, logic r, logic v, logic [1:0] c, logic e, logic [3:0] y,
                              logic yv, logic d, logic b, logic rd);
    vec_t t;
    t.u = u; t.r = r; t.v = v; t.c = c; t.e = e;
    t.exp = {y, yv, d, b, rd};
    vecs.push_back(t);
  endfunction

  task automatic idle_all();
    for (int k = 0; k < NU; k++) begin
      rst_s[k] = 1'b0; val_s[k] = 1'b0; code_s[k] = 2'd0; en_s[k] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got;
    int         hi_cnt;
    bit         seen_done;

    idle_all();
    for (int k = 0; k < NU; k++) rst_s[k] = 1'b1;
    repeat (2) @(posedge clk);

    // Unit 0, HOLD=4: reset drops a transfer, then a single code 2.
    add(0, 1, 1, 2'd2, 1, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 1, 2'd2, 1, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 1, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    // Reset in the 2nd slot cycle with a code pending.
    add(0, 0, 1, 2'd0, 1, 4'b0001, 1, 0, 1, 1);
    add(0, 0, 1, 2'd1, 1, 4'b0001, 1, 0, 1, 0);
    add(0, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
`ifndef PR_DEC_SEQ_GAP_EN
    // Back-to-back 0,1,2 with valid held high: stall while pending is full.
    add(0, 0, 1, 2'd0, 1, 4'b0001, 1, 0, 1, 1);
    add(0, 0, 1, 2'd1, 1, 4'b0001, 1, 0, 1, 0);
    add(0, 0, 1, 2'd2, 1, 4'b0001, 1, 0, 1, 0);
    add(0, 0, 1, 2'd2, 1, 4'b0001, 1, 1, 1, 0);
    add(0, 0, 1, 2'd2, 1, 4'b0010, 1, 0, 1, 1);
    add(0, 0, 1, 2'd2, 1, 4'b0010, 1, 0, 1, 0);
    add(0, 0, 0, 2'd0, 0, 4'b0010, 1, 0, 1, 0);
    add(0, 0, 0, 2'd0, 0, 4'b0010, 1, 1, 1, 0);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0100, 1, 1, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    // Bypass: code offered exactly on the last slot cycle with pending empty.
    add(0, 0, 1, 2'd3, 1, 4'b1000, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b1000, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b1000, 1, 0, 1, 1);
    add(0, 0, 0, 2'd0, 0, 4'b1000, 1, 1, 1, 1);
    add(0, 0, 1, 2'd1, 1, 4'b0010, 1, 0, 1, 1);
    add(0, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
`endif

    // Unit 1, HOLD=2: disabled slot on code 3.
    add(1, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    add(1, 0, 1, 2'd3, 0, 4'b0000, 1, 0, 1, 1);
    add(1, 0, 0, 2'd0, 0, 4'b0000, 1, 1, 1, 1);
    add(1, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);

`ifndef PR_DEC_SEQ_GAP_EN
    // Unit 2, HOLD=1: streaming 3,2,1,0 at full rate.
    add(2, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    add(2, 0, 1, 2'd3, 1, 4'b1000, 1, 1, 1, 1);
    add(2, 0, 1, 2'd2, 1, 4'b0100, 1, 1, 1, 1);
    add(2, 0, 1, 2'd1, 1, 4'b0010, 1, 1, 1, 1);
    add(2, 0, 1, 2'd0, 1, 4'b0001, 1, 1, 1, 1);
    add(2, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
`endif

    // Unit 3, HOLD=3: codes 1,2 back-to-back.
    add(3, 1, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);
    add(3, 0, 1, 2'd1, 1, 4'b0010, 1, 0, 1, 1);
    add(3, 0, 1, 2'd2, 1, 4'b0010, 1, 0, 1, 0);
    add(3, 0, 0, 2'd0, 0, 4'b0010, 1, 1, 1, 0);
`ifdef PR_DEC_SEQ_GAP_EN
    add(3, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 1, 1);
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 1, 1, 1);
`else
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 0, 1, 1);
    add(3, 0, 0, 2'd0, 0, 4'b0100, 1, 1, 1, 1);
`endif
    add(3, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      idle_all();
      rst_s[vecs[i].u]  = vecs[i].r;
      val_s[vecs[i].u]  = vecs[i].v;
      code_s[vecs[i].u] = vecs[i].c;
      en_s[vecs[i].u]   = vecs[i].e;
      @(posedge clk);
      #1;
      got = {y_w[vecs[i].u], yv_w[vecs[i].u], done_w[vecs[i].u], busy_w[vecs[i].u],
             rdy_w[vecs[i].u]};
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d unit%0d {y,yv,done,busy,rdy} got %b want %b", i, vecs[i].u, got,
                 vecs[i].exp);
      end
    end

    // Hand-written: count slot length on unit 0 with a bounded wait for done.
    @(negedge clk);
    idle_all();
    rst_s[0] = 1'b1;
    @(negedge clk);
    idle_all();
    val_s[0] = 1'b1; code_s[0] = 2'd1; en_s[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    idle_all();
    hi_cnt = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (y_w[0] == 4'b0010 && yv_w[0]) hi_cnt++;
      if (done_w[0]) seen_done = 1'b1;
      if (!seen_done) @(negedge clk);
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL slot_done_timeout got no done want done within 20 cycles");
    end
    checks++;
    if (hi_cnt != 4) begin
      errors++;
      $display("FAIL slot_len got %0d want 4", hi_cnt);
    end
    @(negedge clk);
    checks++;
    if (y_w[0] !== 4'b0000 || yv_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL slot_end_idle got y=%b yv=%b busy=%b want y=0000 yv=0 busy=0", y_w[0],
               yv_w[0], busy_w[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
